// File: rtl/regfile_pkg.sv
// Shared register-file types and ABI register indices.
// Imported by regfile_sb and regfile_wb_sel.
package regfile_pkg;

    localparam int RF_XLEN  = 64;
    localparam int RF_NREGS = 32;

    localparam int ZERO = 0;
    localparam int RA   = 1;
    localparam int SP   = 2;
    localparam int A0   = 10;
    localparam int A1   = 11;
    localparam int A2   = 12;
    localparam int A3   = 13;
    localparam int A4   = 14;
    localparam int A5   = 15;
    localparam int A6   = 16;
    localparam int A7   = 17;

    typedef logic [$clog2(RF_NREGS)-1:0] reg_addr_t;
    typedef logic [RF_XLEN-1:0]          xlen_t;

endpackage

// File: rtl/regfile_wb_sel.sv
// Writeback match for one query address; the highest port index wins.
// Address 0 never hits, so x0 can neither be bypassed nor written.
module regfile_wb_sel
    import regfile_pkg::*;
#(
    parameter int NUM_WB = 2,
    parameter int AW     = 5,
    parameter int XLEN   = 64
) (
    input  logic [NUM_WB-1:0]           wb_en,
    input  logic [NUM_WB-1:0][AW-1:0]   wb_addr,
    input  logic [NUM_WB-1:0][XLEN-1:0] wb_data,
    input  logic [AW-1:0]               q_addr,
    output logic                        hit,
    output logic [XLEN-1:0]             data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int j = 0; j < NUM_WB; j++) begin
            if (wb_en[j] && wb_addr[j] == q_addr && q_addr != AW'(ZERO)) begin
                hit  = 1'b1;
                data = wb_data[j];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write bypass and pending scoreboard.
// Define REGFILE_ECALL_TAP_EN to expose raw a0..a7 for the ecall handler.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WB = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_RD-1:0][AW-1:0]   rd_addr,
    output logic [NUM_RD-1:0][XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic                        issue_en,
    input  logic [AW-1:0]               issue_addr,
    input  logic [NUM_WB-1:0]           wb_en,
    input  logic [NUM_WB-1:0][AW-1:0]   wb_addr,
    input  logic [NUM_WB-1:0][XLEN-1:0] wb_data,
    input  logic                        flush,
    output logic [AW:0]                 pending_cnt
`ifdef REGFILE_ECALL_TAP_EN
    ,
    output logic [XLEN-1:0]             a0,
    output logic [XLEN-1:0]             a1,
    output logic [XLEN-1:0]             a2,
    output logic [XLEN-1:0]             a3,
    output logic [XLEN-1:0]             a4,
    output logic [XLEN-1:0]             a5,
    output logic [XLEN-1:0]             a6,
    output logic [XLEN-1:0]             a7
`endif
);

    if (NUM_RD < 1 || NUM_WB < 1 || NREGS < 2 ||
        (NREGS & (NREGS - 1)) != 0) begin : g_param_err
        $fatal(1, "regfile_sb: illegal NUM_RD/NUM_WB/NREGS");
    end

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    logic [NREGS-1:0] wr_hit;
    logic [XLEN-1:0]  wr_data [NREGS];
    logic [NUM_RD-1:0] rd_hit;
    logic [XLEN-1:0]  rd_byp [NUM_RD];

    for (genvar r = 0; r < NREGS; r++) begin : g_wr
        regfile_wb_sel #(
            .NUM_WB (NUM_WB),
            .AW     (AW),
            .XLEN   (XLEN)
        ) u_wr_sel (
            .wb_en   (wb_en),
            .wb_addr (wb_addr),
            .wb_data (wb_data),
            .q_addr  (AW'(r)),
            .hit     (wr_hit[r]),
            .data    (wr_data[r])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_wb_sel #(
            .NUM_WB (NUM_WB),
            .AW     (AW),
            .XLEN   (XLEN)
        ) u_rd_sel (
            .wb_en   (wb_en),
            .wb_addr (wb_addr),
            .wb_data (wb_data),
            .q_addr  (rd_addr[i]),
            .hit     (rd_hit[i]),
            .data    (rd_byp[i])
        );

        assign rd_data[i] = rd_hit[i] ? rd_byp[i] : regs_q[rd_addr[i]];
        assign rd_busy[i] = pend_q[rd_addr[i]] & ~rd_hit[i];
    end

    // Order matters: writeback clears, flush clears all, issue sets last.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        cnt_d  = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (wr_hit[r]) begin
                regs_d[r] = wr_data[r];
                pend_d[r] = 1'b0;
            end
        end
        if (flush) begin
            pend_d = '0;
        end
        if (issue_en && issue_addr != AW'(ZERO)) begin
            pend_d[issue_addr] = 1'b1;
        end
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, pend_d[r]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

`ifdef REGFILE_ECALL_TAP_EN
    assign a0 = regs_q[A0];
    assign a1 = regs_q[A1];
    assign a2 = regs_q[A2];
    assign a3 = regs_q[A3];
    assign a4 = regs_q[A4];
    assign a5 = regs_q[A5];
    assign a6 = regs_q[A6];
    assign a7 = regs_q[A7];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: bypass, write priority, scoreboard, reset.
// Expected values are hand-computed constants.
module tb_regfile_sb;

    localparam int AW = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [1:0][AW-1:0]   rd_addr;
    logic [1:0][63:0]     rd_data;
    logic [1:0]           rd_busy;
    logic                 issue_en;
    logic [AW-1:0]        issue_addr;
    logic [1:0]           wb_en;
    logic [1:0][AW-1:0]   wb_addr;
    logic [1:0][63:0]     wb_data;
    logic                 flush;
    logic [AW:0]          pending_cnt;
`ifdef REGFILE_ECALL_TAP_EN
    logic [63:0] a0, a1, a2, a3, a4, a5, a6, a7;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .pending_cnt (pending_cnt)
`ifdef REGFILE_ECALL_TAP_EN
        ,
        .a0 (a0), .a1 (a1), .a2 (a2), .a3 (a3),
        .a4 (a4), .a5 (a5), .a6 (a6), .a7 (a7)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_en   = 1'b0;
        issue_addr = '0;
        wb_en      = '0;
        wb_addr    = '0;
        wb_data    = '0;
        flush      = 1'b0;
    endtask

    task automatic wb(input int p, input int a, input logic [63:0] d);
        wb_en[p]   = 1'b1;
        wb_addr[p] = AW'(a);
        wb_data[p] = d;
    endtask

    task automatic issue(input int a);
        issue_en   = 1'b1;
        issue_addr = AW'(a);
    endtask

    initial begin
        idle();
        rd_addr = '0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        rd_addr[0] = 5;
        rd_addr[1] = 0;
        #1;
        chk("rst_x5", rd_data[0], 64'h0);
        chk("rst_x0", rd_data[1], 64'h0);
        chk("rst_busy", {62'b0, rd_busy}, 64'h0);
        chk("rst_cnt", 64'(pending_cnt), 64'h0);

        wb(0, 5, 64'hDEAD_BEEF);
        #1;
        chk("byp_x5", rd_data[0], 64'hDEAD_BEEF);
        tick();
        idle();
        #1;
        chk("st_x5", rd_data[0], 64'hDEAD_BEEF);

        rd_addr[0] = 7;
        wb(0, 7, 64'h1);
        wb(1, 7, 64'h2);
        #1;
        chk("conf_byp", rd_data[0], 64'h2);
        tick();
        idle();
        wb(0, 0, 64'h55);
        rd_addr[1] = 0;
        #1;
        chk("x0_byp", rd_data[1], 64'h0);
        chk("conf_st", rd_data[0], 64'h2);
        tick();
        idle();
        #1;
        chk("x0_st", rd_data[1], 64'h0);

        rd_addr[0] = 9;
        issue(9);
        #1;
        chk("iss_hidden", {63'b0, rd_busy[0]}, 64'h0);
        tick();
        idle();
        #1;
        chk("iss_busy", {63'b0, rd_busy[0]}, 64'h1);
        chk("iss_cnt", 64'(pending_cnt), 64'h1);
        wb(0, 9, 64'h42);
        #1;
        chk("wb_busy", {63'b0, rd_busy[0]}, 64'h0);
        chk("wb_byp", rd_data[0], 64'h42);
        tick();
        idle();
        #1;
        chk("wb_cnt", 64'(pending_cnt), 64'h0);
        chk("wb_clr", {63'b0, rd_busy[0]}, 64'h0);

        rd_addr[1] = 3;
        issue(3);
        wb(1, 3, 64'h33);
        tick();
        idle();
        #1;
        chk("iss_wins", {63'b0, rd_busy[1]}, 64'h1);
        chk("iss_wins_cnt", 64'(pending_cnt), 64'h1);
        chk("iss_wins_data", rd_data[1], 64'h33);
        issue(4);
        tick();
        issue(6);
        tick();
        idle();
        #1;
        chk("cnt3", 64'(pending_cnt), 64'h3);
        flush = 1'b1;
        issue(8);
        tick();
        idle();
        rd_addr[0] = 8;
        #1;
        chk("flush_cnt", 64'(pending_cnt), 64'h1);
        chk("flush_x8", {63'b0, rd_busy[0]}, 64'h1);
        chk("flush_x3", {63'b0, rd_busy[1]}, 64'h0);

        issue(1);
        wb(0, 10, 64'hAB);
        tick();
        idle();
        issue(2);
        tick();
        issue(3);
        tick();
        issue(4);
        tick();
        idle();
        rd_addr[1] = 10;
        #1;
        chk("pre_cnt", 64'(pending_cnt), 64'h5);
        chk("pre_x10", rd_data[1], 64'hAB);
`ifdef REGFILE_ECALL_TAP_EN
        chk("tap_a0", a0, 64'hAB);
`endif
        reset = 1'b1;
        wb(0, 2, 64'h77);
        wb(1, 10, 64'h99);
        issue(5);
        tick();
        reset = 1'b0;
        idle();
        rd_addr[0] = 2;
        rd_addr[1] = 10;
        #1;
        chk("mid_cnt", 64'(pending_cnt), 64'h0);
        chk("mid_x2", rd_data[0], 64'h0);
        chk("mid_x10", rd_data[1], 64'h0);
        chk("mid_busy", {62'b0, rd_busy}, 64'h0);
        rd_addr[0] = 1;
        rd_addr[1] = 5;
        #1;
        chk("mid_x1b", {63'b0, rd_busy[0]}, 64'h0);
        chk("mid_x5", rd_data[1], 64'h0);
        chk("mid_x5b", {63'b0, rd_busy[1]}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
